cache_writeback_ctrl: RTL
=========================

# cache_writeback_ctrl

Write-back sequencer for the RRAM macro: the opposite direction of the read-to-cache path tracked by `state_counter`. On a start request it walks a contiguous, wrapping range of the 32-entry cache, one word at a time. For each word it performs a synchronous cache read, then drives the RRAM write interface with a timed active-low write pulse. The pulse width is normal or forming. The block sits between the cache array and the RRAM macro's CE/WE pins and reports per-word and end-of-burst events to the controller.

## Interface
Parameters:
- `DATA_W`, 8, cache/RRAM word width
- `ADDR_W`, 5, cache and RRAM address width (depth 2^ADDR_W = 32)
- `WR_PULSE`, 4, WE_L low cycles for a normal write (≥1)
- `FORM_PULSE`, 16, WE_L low cycles for a forming write (≥1)
- `RECOVER`, 2, cycles with WE_L high and CE_L low after each pulse (≥1)

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  block enable; `start` is ignored while low
- `start`  in  1  one-cycle burst request, sampled in IDLE only
- `forming`  in  1  captured at start; selects FORM_PULSE for the whole burst
- `abort`  in  1  ends the burst after the current word's RECOVER
- `base_add`  in  ADDR_W  first cache/RRAM address, captured at start
- `len`  in  ADDR_W+1  word count, captured at start; 0 means no-op, values >32 clamp to 32
- `cache_dout`  in  DATA_W  cache read data, valid one cycle after `cache_re`
- `cache_re`  out  1  cache read strobe
- `cache_add`  out  ADDR_W  cache read address
- `rram_add`  out  ADDR_W  RRAM write address
- `rram_din`  out  DATA_W  RRAM write data (registered)
- `CE_L`  out  1  RRAM chip enable, active low
- `WE_L`  out  1  RRAM write enable, active low
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle end-of-burst pulse
- `write_count_flag`  out  1  one-cycle pulse per completed normal write
- `forming_count_flag`  out  1  one-cycle pulse per completed forming write

## Operation
- States: IDLE → FETCH → LATCH → SETUP → PULSE → RECOVER → (FETCH | DONE) → IDLE.
- IDLE:
  - On `en & start`, capture `base_add`, clamped `len`, `forming`; clear the word counter.
  - If clamped len = 0, go to DONE; otherwise go to FETCH.
- FETCH: `cache_re`=1, `cache_add` = ptr, where ptr = (base + idx) mod 32; wrap at 31 → 0.
- LATCH: `rram_din` ← `cache_dout`; `rram_add` ← ptr.
- SETUP: `CE_L`=0, `WE_L`=1 for 1 cycle (address and data setup).
- PULSE: `CE_L`=0, `WE_L`=0 for WR_PULSE or FORM_PULSE cycles, counted by the pulse counter.
- RECOVER: `CE_L`=0, `WE_L`=1 for RECOVER cycles.
  - On the last RECOVER cycle, pulse `write_count_flag` or `forming_count_flag` and increment idx.
  - If idx = len or `abort` has been latched, go to DONE; otherwise go to FETCH.
- `abort`:
  - Latched sticky in any non-IDLE state.
  - Never shortens a pulse; the current word always completes.
  - Abort in FETCH/LATCH/SETUP still completes that word.
- DONE: `done`=1 for one cycle; `CE_L`=1; return to IDLE.
- `start` while busy is ignored. `en` is consulted only in IDLE.

## Timing
- Reset values: state IDLE, `CE_L`=1, `WE_L`=1, `cache_re`=0, `done`=0, both flags 0, `busy`=0, `cache_add`/`rram_add`/`rram_din`=0.
- Reset mid-pulse deasserts `WE_L` and `CE_L` asynchronously; no flag or done is emitted.
- Cycles per word = 3 + pulse + RECOVER. Defaults: 9 normal, 21 forming.
- Burst latency, start to done: 1 + len×(3 + pulse + RECOVER) cycles. `done` asserts the cycle after the last RECOVER.
- `WE_L` is never low while `CE_L` is high. `rram_add`/`rram_din` are stable from SETUP through RECOVER.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `rram_pkg`: ADDR_W, DATA_W, DEPTH, state encoding constants, default pulse widths shared with the read-side counter.
- One natural sub-module, `pulse_timer`: a loadable down-counter that produces `pulse_done`, reused for PULSE and RECOVER.

## Test plan
- Reset, then `start` with base=0, len=1, forming=0, cache[0]=8'hA5:
  - `cache_re` asserts in cycle 1; `rram_din`=A5 and `rram_add`=0.
  - `WE_L` is low for exactly 4 cycles; `write_count_flag` pulses once; `done` asserts at cycle 10.
- base=30, len=4: `rram_add` sequence 30, 31, 0, 1; 4 `write_count_flag` pulses; `done` after 1+36 cycles.
- forming=1, len=2: `WE_L` low 16 cycles per word; only `forming_count_flag` pulses (2×); `write_count_flag` stays 0.
- len=0 → `done` the cycle after start, with no `cache_re` and no `CE_L` activity.
- len=40 → exactly 32 writes.
- `abort` during word 2's PULSE of a len=8 burst:
  - The pulse completes at full width; 2 flags in total; `done` follows word 2's RECOVER.
- `rst` asserted mid-PULSE: `WE_L`/`CE_L` go high immediately.
  - A new start with `en`=1 after reset runs normally.
  - `start` with `en`=0 produces no activity.

Source files
------------

// File: rtl/cache_writeback_ctrl_pkg.sv
// cache_writeback_ctrl_pkg: shared widths, pulse defaults and sequencer state encoding for the RRAM write-back path
package cache_writeback_ctrl_pkg;
    localparam int ADDR_W         = 5;
    localparam int DATA_W         = 8;
    localparam int DEPTH          = 1 << ADDR_W;
    localparam int DEF_WR_PULSE   = 4;
    localparam int DEF_FORM_PULSE = 16;
    localparam int DEF_RECOVER    = 2;
    localparam int CNT_W          = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_SETUP, S_PULSE, S_RECOVER, S_DONE
    } state_t;

    function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] l);
        return (l > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : l;
    endfunction
endpackage

// File: rtl/cache_writeback_ctrl_if.sv
// cache_writeback_ctrl_if: controller, cache read port and RRAM write pins of the write-back sequencer
interface cache_writeback_ctrl_if #(
    parameter int DATA_W = cache_writeback_ctrl_pkg::DATA_W,
    parameter int ADDR_W = cache_writeback_ctrl_pkg::ADDR_W
);
    logic              en;
    logic              start;
    logic              forming;
    logic              abort;
    logic [ADDR_W-1:0] base_add;
    logic [ADDR_W:0]   len;
    logic [DATA_W-1:0] cache_dout;
    logic              cache_re;
    logic [ADDR_W-1:0] cache_add;
    logic [ADDR_W-1:0] rram_add;
    logic [DATA_W-1:0] rram_din;
    logic              CE_L;
    logic              WE_L;
    logic              busy;
    logic              done;
    logic              write_count_flag;
    logic              forming_count_flag;

    modport slave (
        input  en, start, forming, abort, base_add, len, cache_dout,
        output cache_re, cache_add, rram_add, rram_din, CE_L, WE_L, busy, done,
               write_count_flag, forming_count_flag
    );
    modport master (
        output en, start, forming, abort, base_add, len, cache_dout,
        input  cache_re, cache_add, rram_add, rram_din, CE_L, WE_L, busy, done,
               write_count_flag, forming_count_flag
    );
endinterface

// File: rtl/cache_writeback_ctrl_pulse_timer.sv
// pulse_timer: loadable down-counter; pulse_done marks the final cycle of a loaded interval
module pulse_timer
    import cache_writeback_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             pulse_done
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - 1'b1 : '0);

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

    assign cnt        = cnt_q;
    assign pulse_done = (cnt_q == '0);
endmodule

// File: rtl/cache_writeback_ctrl.sv
// cache_writeback_ctrl: walks a wrapping cache range and writes each word to RRAM with a timed WE_L pulse
module cache_writeback_ctrl
    import cache_writeback_ctrl_pkg::*;
#(
    parameter int DATA_W     = cache_writeback_ctrl_pkg::DATA_W,
    parameter int ADDR_W     = cache_writeback_ctrl_pkg::ADDR_W,
    parameter int WR_PULSE   = DEF_WR_PULSE,
    parameter int FORM_PULSE = DEF_FORM_PULSE,
    parameter int RECOVER    = DEF_RECOVER
) (
    input logic                  clk,
    input logic                  rst,
    cache_writeback_ctrl_if.slave bus
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, cache_add_q, cache_add_d, rram_add_q, rram_add_d, ptr;
    logic [ADDR_W:0]   len_q, len_d, idx_q, idx_d, len_c;
    logic [DATA_W-1:0] rram_din_q, rram_din_d;
    logic              form_q, form_d, abort_q, abort_d;
    logic              cache_re_q, cache_re_d, ce_l_q, ce_l_d, we_l_q, we_l_d;
    logic              busy_q, busy_d, done_q, done_d, wflag_q, wflag_d, fflag_q, fflag_d;
    logic              tmr_load, tmr_done, last_rec_next;
    logic [CNT_W-1:0]  tmr_val, tmr_cnt;

    pulse_timer u_timer (
        .clk(clk), .rst(rst), .load(tmr_load), .load_val(tmr_val),
        .cnt(tmr_cnt), .pulse_done(tmr_done)
    );

    assign len_c    = clamp_len(bus.len);
    assign ptr      = base_q + idx_q[ADDR_W-1:0];
    assign tmr_load = (state_q == S_SETUP) | (state_q == S_PULSE & tmr_done);
    assign tmr_val  = (state_q == S_SETUP) ? CNT_W'((form_q ? FORM_PULSE : WR_PULSE) - 1)
                                           : CNT_W'(RECOVER - 1);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        form_d     = form_q;
        idx_d      = idx_q;
        rram_add_d = rram_add_q;
        rram_din_d = rram_din_q;
        case (state_q)
            S_IDLE: if (bus.en & bus.start) begin
                base_d  = bus.base_add;
                len_d   = len_c;
                form_d  = bus.forming;
                idx_d   = '0;
                state_d = (len_c == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                rram_din_d = bus.cache_dout;
                rram_add_d = ptr;
                state_d    = S_SETUP;
            end
            S_SETUP: state_d = S_PULSE;
            S_PULSE: state_d = tmr_done ? S_RECOVER : S_PULSE;
            S_RECOVER: if (tmr_done) begin
                idx_d   = idx_q + 1'b1;
                state_d = (idx_d == len_q || abort_q || bus.abort) ? S_DONE : S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
        // abort is sticky for the whole burst but only ever ends it at a word boundary
        abort_d       = (state_q == S_IDLE) ? 1'b0 : (abort_q | bus.abort);
        cache_add_d   = (state_d == S_FETCH) ? base_d + idx_d[ADDR_W-1:0] : cache_add_q;
        last_rec_next = (state_q == S_PULSE & tmr_done & RECOVER == 1) |
                        (state_q == S_RECOVER & tmr_cnt == CNT_W'(1));
        wflag_d       = last_rec_next & ~form_q;
        fflag_d       = last_rec_next & form_q;
        cache_re_d    = (state_d == S_FETCH);
        ce_l_d        = !(state_d inside {S_SETUP, S_PULSE, S_RECOVER});
        we_l_d        = (state_d != S_PULSE);
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            form_q      <= 1'b0;
            idx_q       <= '0;
            abort_q     <= 1'b0;
            cache_add_q <= '0;
            rram_add_q  <= '0;
            rram_din_q  <= '0;
            cache_re_q  <= 1'b0;
            ce_l_q      <= 1'b1;
            we_l_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wflag_q     <= 1'b0;
            fflag_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            form_q      <= form_d;
            idx_q       <= idx_d;
            abort_q     <= abort_d;
            cache_add_q <= cache_add_d;
            rram_add_q  <= rram_add_d;
            rram_din_q  <= rram_din_d;
            cache_re_q  <= cache_re_d;
            ce_l_q      <= ce_l_d;
            we_l_q      <= we_l_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wflag_q     <= wflag_d;
            fflag_q     <= fflag_d;
        end

    assign bus.cache_re           = cache_re_q;
    assign bus.cache_add          = cache_add_q;
    assign bus.rram_add           = rram_add_q;
    assign bus.rram_din           = rram_din_q;
    assign bus.CE_L               = ce_l_q;
    assign bus.WE_L               = we_l_q;
    assign bus.busy               = busy_q;
    assign bus.done               = done_q;
    assign bus.write_count_flag   = wflag_q;
    assign bus.forming_count_flag = fflag_q;
endmodule
